bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Parametrised round-robin bus arbiter for N bus masters with active-low request/grant handshakes, bus lock for atomic sequences, and an optional hold-cycle limit that forces rotation. It sits between the master request lines and the bus multiplexer, and replaces the fixed four-master arbiter for bus configurations with any master count from 2 to 16.

## Interface
- N_MST, 4: number of masters, 2..16
- PARK_MST, 0: owner after reset, 0..N_MST-1
- HOLD_MAX, 16: maximum consecutive ownership cycles while others wait, 2..255; used only with the macro
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_  in  N_MST  per-master request, active low
- lock_  in  N_MST  per-master lock, active low; honoured only for the current owner
- grnt_  out  N_MST  per-master grant, active low; exactly one bit low at all times
- owner  out  OW  index of current owner; OW = clog2(N_MST)
- chg  out  1  one-cycle pulse in the first cycle after ownership changes

## Operation
- One registered state: `owner`. `grnt_` is the active-low one-hot decode of `owner`, with no other logic.
- The bus is always granted to someone. When there are no requests, `owner` is kept (parked on the last owner).
- Next-owner decision, evaluated each rising edge, first match wins:
  1. Owner has `lock_` low: keep the owner, regardless of `req_`. This covers request gaps inside atomic sequences.
  2. Owner has `req_` low and no forced rotation applies (see Configuration): keep the owner.
  3. Otherwise scan `req_` in order owner+1, owner+2, … modulo N_MST. The current owner is scanned last. Grant the first master with `req_` low.
  4. No request is asserted: keep the owner.
- Index arithmetic wraps modulo N_MST. Non-power-of-two N_MST must never produce an out-of-range index.
- `lock_` from a non-owner is ignored.
- `chg` is a registered pulse, high for exactly one cycle after any edge where `owner` changed.

## Timing
- Reset, asynchronous: `owner`=PARK_MST, `grnt_` has only bit PARK_MST low, `chg`=0, hold counter=0.
- Grant latency:
  - A request to an idle parked bus is granted after one edge.
  - A request that arrives while another master owns the bus is granted on the edge after the owner releases `req_` (and `lock_`).
- Handover is gapless. The old grant rises and the new grant falls on the same edge, so there are never zero or two grants.
- Simultaneous requests are resolved by round-robin distance from the current owner, never by fixed index.
- A reset mid-ownership returns the arbiter to PARK_MST immediately. No pulse is generated on `chg`.

## Configuration
- Macro: `BUS_ARB_RR_HOLD_LIMIT_EN`
- With the macro defined:
  - A hold counter of width clog2(HOLD_MAX) counts the cycles the owner retains the bus while at least one other master has `req_` low. The counter saturates.
  - The counter clears on every ownership change and whenever no other master is requesting.
  - When the counter equals HOLD_MAX-1, the owner's `lock_` is high, and another request is pending, rule 2 does not apply. Rotation happens on that edge.
  - The maximum wait for any requester is therefore bounded by (N_MST-1)·HOLD_MAX cycles, excluding locked periods.
- Without the macro: no counter exists, HOLD_MAX is ignored, and the owner keeps the bus for as long as `req_` is low.

## Structure
- Package `bus_arb_pkg`: N_MST limits (min 2, max 16), default HOLD_MAX, and a function for the OW width (minimum 1).
- Sub-module `rr_pick`: combinational rotate-priority search. Inputs are the request vector and the start index; outputs are the winning index and a found flag. The top level holds the `owner` register, the lock/hold logic, the counter and `chg`.

## Test plan
- Reset with N_MST=4, PARK_MST=2 → `grnt_`=4'b1011, `owner`=2, `chg`=0. Then assert `req_`[0] low → after one edge `owner`=0, `chg` pulses once.
- N_MST=4, owner=1, all `req_` low; each owner releases one cycle after grant → grant order 2,3,0,1. Exactly one `grnt_` bit low every cycle.
- N_MST=5: owner=4 releases with only `req_`[0] low → `owner` wraps to 0. `owner` never takes a value above 4.
- Owner 1 holds `lock_` low and drops `req_` for 3 cycles while `req_`[2] is low → `owner` stays 1. One edge after `lock_` rises, `owner` becomes 2.
- With the macro, HOLD_MAX=4: owner 0 and master 3 both requesting continuously → `owner` switches to 3 after exactly 4 cycles. Repeat with owner `lock_` low → no switch. Without the macro → no switch.
- Assert rst_n low mid-sequence, asynchronously, while owner=3 → `grnt_` immediately shows only PARK_MST low, and the hold counter clears.

Source files
------------

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bus_arb_pkg
//  Purpose : Shared limits, defaults, decision encoding and width helper for
//            the round-robin bus arbiter (bus_arbiter_rr, rr_pick).
//  Contents:
//    N_MST_MIN / N_MST_MAX : supported master count range (2..16)
//    HOLD_MAX_DEF          : default hold-cycle limit
//    arb_dec_e             : reason code for the next-owner decision
//    ow_width()            : clog2 with a floor of 1 bit
//  Revision: 1.0  initial release
// ============================================================================
package bus_arb_pkg;

  localparam int N_MST_MIN    = 2;
  localparam int N_MST_MAX    = 16;
  localparam int HOLD_MAX_DEF = 16;

  // Why the owner register takes the value it does on the next edge.
  typedef enum logic [1:0] {
    DEC_LOCK   = 2'd0,  // owner holds lock_, kept unconditionally
    DEC_KEEP   = 2'd1,  // owner still requesting, no forced rotation
    DEC_ROTATE = 2'd2,  // handed to the next requester in rotate order
    DEC_PARK   = 2'd3   // nobody requesting, bus stays parked
  } arb_dec_e;

  // Index width for n items; a 2-entry space still needs one bit.
  function automatic int ow_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Purpose : Combinational rotate-priority search. Scans the request vector
//            starting one position after `start`, wrapping modulo N, so that
//            `start` itself is examined last.
//  Ports   :
//    req   in  N  request vector, active high
//    start in  W  index the scan rotates from (current owner)
//    idx   out W  index of the first requester found in rotate order
//    found out 1  high when any request bit is set
//  Revision: 1.0  initial release
// ============================================================================
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = ow_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  int pos;

  // Walk the distances from farthest to nearest so the nearest requester
  // is the last one written and therefore wins. Distance N lands on start.
  always_comb begin
    idx   = start;
    found = 1'b0;
    pos   = 0;
    for (int k = N; k >= 1; k--) begin
      pos = int'(start) + k;
      // start < N and k <= N, so one wrap is enough; the second guards
      // against an out-of-range start so the index can never exceed N-1.
      if (pos >= N) pos = pos - N;
      if (pos >= N) pos = pos - N;
      if (req[pos[W-1:0]]) begin
        idx   = pos[W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module  : bus_arbiter_rr
//  Purpose : Round-robin bus arbiter for N_MST masters with active-low
//            request/grant, bus lock for atomic sequences and an optional
//            hold-cycle limit that forces rotation.
//  Parameters:
//    N_MST    number of masters (2..16)
//    PARK_MST owner after reset (0..N_MST-1)
//    HOLD_MAX max consecutive ownership cycles while others wait (2..255);
//             only used when BUS_ARB_RR_HOLD_LIMIT_EN is defined
//  Ports:
//    clk    in  1      clock, rising edge
//    rst_n  in  1      asynchronous active-low reset
//    req_   in  N_MST  per-master request, active low
//    lock_  in  N_MST  per-master lock, active low (owner only)
//    grnt_  out N_MST  per-master grant, active low, exactly one low
//    owner  out OW     index of current owner
//    chg    out 1      one-cycle pulse after an ownership change
//  Build option:
//    BUS_ARB_RR_HOLD_LIMIT_EN  enables the saturating hold counter
//  Revision: 1.0  initial release
// ============================================================================
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter  int N_MST    = 4,
  parameter  int PARK_MST = 0,
  parameter  int HOLD_MAX = HOLD_MAX_DEF,
  localparam int OW       = ow_width(N_MST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_MST-1:0] req_,
  input  logic [N_MST-1:0] lock_,
  output logic [N_MST-1:0] grnt_,
  output logic [OW-1:0]    owner,
  output logic             chg
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (N_MST < N_MST_MIN || N_MST > N_MST_MAX) begin : g_chk_n_mst
    $error("bus_arbiter_rr: N_MST out of range");
  end
  if (PARK_MST < 0 || PARK_MST >= N_MST) begin : g_chk_park
    $error("bus_arbiter_rr: PARK_MST out of range");
  end
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_chk_hold
    $error("bus_arbiter_rr: HOLD_MAX out of range");
  end

  localparam logic [OW-1:0] PARK_IDX = OW'(PARK_MST);

  // --------------------------------------------------------------------------
  // Active-high views of the handshake inputs
  // --------------------------------------------------------------------------
  logic [N_MST-1:0] req;
  logic [N_MST-1:0] lock;
  logic             owner_req;
  logic             owner_lock;
  logic             others_req;
  logic             force_rot;

  assign req        = ~req_;
  assign lock       = ~lock_;
  assign owner_req  = req[owner];
  // Only the owner's lock bit is ever looked at; other masters' locks
  // have no path into the decision.
  assign owner_lock = lock[owner];
  // grnt_ is high for every master except the owner, so it doubles as the
  // "everyone else" mask.
  assign others_req = |(req & grnt_);

  // --------------------------------------------------------------------------
  // Rotate-priority search starting after the current owner
  // --------------------------------------------------------------------------
  logic [OW-1:0] pick_idx;
  logic          pick_found;

  rr_pick #(
    .N     (N_MST)
  ) u_rr_pick (
    .req   (req),
    .start (owner),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // --------------------------------------------------------------------------
  // Next-owner decision
  // --------------------------------------------------------------------------
  arb_dec_e      dec;
  logic [OW-1:0] owner_nxt;
  logic          chg_nxt;

  always_comb begin
    dec = DEC_PARK;
    if (owner_lock) begin
      // Lock bridges request gaps inside an atomic sequence.
      dec = DEC_LOCK;
    end else if (owner_req && !force_rot) begin
      dec = DEC_KEEP;
    end else if (pick_found) begin
      // If the owner is still requesting here, rotation was forced and
      // another master is waiting, so the scan lands on someone else.
      dec = DEC_ROTATE;
    end
  end

  always_comb begin
    owner_nxt = owner;
    if (dec == DEC_ROTATE) begin
      owner_nxt = pick_idx;
    end
    chg_nxt = (owner_nxt != owner);
  end

  // --------------------------------------------------------------------------
  // Optional hold-cycle limit
  // --------------------------------------------------------------------------
`ifdef BUS_ARB_RR_HOLD_LIMIT_EN
  localparam int          HW        = ow_width(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;

  // Saturating at HOLD_LAST rather than all-ones keeps the compare live
  // after a long locked stretch for non-power-of-two HOLD_MAX.
  always_comb begin
    hold_nxt = hold_cnt;
    if ((owner_nxt != owner) || !others_req) begin
      hold_nxt = '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_nxt = hold_cnt + 1'b1;
    end
  end

  assign force_rot = (hold_cnt == HOLD_LAST) && !owner_lock && others_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_nxt;
    end
  end
`else
  assign force_rot = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= PARK_IDX;
      chg   <= 1'b0;
    end else begin
      owner <= owner_nxt;
      chg   <= chg_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Grant decode: pure one-hot (active-low) of the owner register, so the
  // old grant rises and the new one falls on the same edge.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_MST; i++) begin : g_grnt
    assign grnt_[i] = (owner != OW'(i));
  end

endmodule : bus_arbiter_rr
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bus_arbiter_rr
//  Purpose : Self-checking bench for bus_arbiter_rr. Two instances:
//            N_MST=4/PARK_MST=2/HOLD_MAX=4 and N_MST=5/PARK_MST=0.
//            Each expected ownership change is queued when stimulus is
//            applied; a monitor pops and compares on every chg pulse.
//  Revision: 1.0  initial release
// ============================================================================
module tb_bus_arbiter_rr;

  logic       clk;
  logic       rst_n;

  logic [3:0] req4_;
  logic [3:0] lock4_;
  logic [3:0] grnt4_;
  logic [1:0] owner4;
  logic       chg4;

  logic [4:0] req5_;
  logic [4:0] lock5_;
  logic [4:0] grnt5_;
  logic [2:0] owner5;
  logic       chg5;

  int checks = 0;
  int errors = 0;
  int exp4_q[$];
  int exp5_q[$];

  bus_arbiter_rr #(
    .N_MST    (4),
    .PARK_MST (2),
    .HOLD_MAX (4)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_  (req4_),
    .lock_ (lock4_),
    .grnt_ (grnt4_),
    .owner (owner4),
    .chg   (chg4)
  );

  bus_arbiter_rr #(
    .N_MST    (5),
    .PARK_MST (0),
    .HOLD_MAX (4)
  ) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_  (req5_),
    .lock_ (lock5_),
    .grnt_ (grnt5_),
    .owner (owner5),
    .chg   (chg5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: grant/owner consistency every cycle, scoreboard pop on chg.
  always @(negedge clk) begin
    logic [3:0] d4;
    logic [4:0] d5;
    if (rst_n) begin
      d4 = ~(4'b0001 << owner4);
      d5 = ~(5'b00001 << owner5);
      chk("grnt4_onehot", grnt4_, d4);
      chk("grnt5_onehot", grnt5_, d5);
      chk("owner5_in_range", (owner5 < 3'd5) ? 1 : 0, 1);
      if (chg4) begin
        if (exp4_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL chg4_spurious: got owner %0d expected no change (t=%0t)", owner4, $time);
        end else begin
          chk("owner4_at_chg", owner4, exp4_q.pop_front());
        end
      end
      if (chg5) begin
        if (exp5_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL chg5_spurious: got owner %0d expected no change (t=%0t)", owner5, $time);
        end else begin
          chk("owner5_at_chg", owner5, exp5_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cur;
    int nxt;
    rst_n  = 1'b0;
    req4_  = '1;
    lock4_ = '1;
    req5_  = '1;
    lock5_ = '1;

    // ---------------- reset state ----------------
    step(1);
    chk("rst_owner4", owner4, 2);
    chk("rst_grnt4", grnt4_, 4'b1011);
    chk("rst_chg4", chg4, 0);
    chk("rst_owner5", owner5, 0);
    chk("rst_grnt5", grnt5_, 5'b11110);
    step(1);
    rst_n = 1'b1;
    step(1);

    // ---------------- idle parked bus, one-edge grant ----------------
    req4_ = 4'b1110;
    exp4_q.push_back(0);
    step(1);
    chk("park_grant_owner", owner4, 0);
    chk("park_grant_chg", chg4, 1);
    step(1);
    chk("chg_single_pulse", chg4, 0);
    req4_ = '1;
    step(1);
    chk("park_keep", owner4, 0);

    // ---------------- round-robin order 2,3,0,1 ----------------
    req4_ = 4'b1101;
    exp4_q.push_back(1);
    step(1);
    chk("rr_start", owner4, 1);
    cur = 1;
    for (int k = 0; k < 4; k++) begin
      req4_ = 4'b0001 << cur;   // owner released, everyone else requesting
      nxt = (cur + 1) % 4;
      exp4_q.push_back(nxt);
      step(1);
      chk("rr_order", owner4, nxt);
      cur = nxt;
    end
    req4_ = '1;
    step(1);
    chk("rr_park", owner4, 1);

    // ---------------- lock across request gap ----------------
    req4_  = 4'b1001;
    lock4_ = 4'b1101;
    step(1);
    chk("lock_keep", owner4, 1);
    req4_ = 4'b1011;
    step(3);
    chk("lock_gap", owner4, 1);
    lock4_ = '1;
    exp4_q.push_back(2);
    step(1);
    chk("lock_release", owner4, 2);
    req4_ = '1;
    step(1);

    // ---------------- N_MST=5 wrap and distance priority ----------------
    req5_ = 5'b01111;
    exp5_q.push_back(4);
    step(1);
    chk("n5_to4", owner5, 4);
    req5_ = 5'b11110;
    exp5_q.push_back(0);
    step(1);
    chk("n5_wrap0", owner5, 0);
    req5_ = 5'b10101;
    exp5_q.push_back(1);
    step(1);
    chk("n5_dist1", owner5, 1);
    req5_ = 5'b10110;
    exp5_q.push_back(3);
    step(1);
    chk("n5_dist3", owner5, 3);
    req5_ = 5'b11010;
    exp5_q.push_back(0);
    step(1);
    chk("n5_wrap_dist", owner5, 0);
    req5_  = 5'b10111;
    lock5_ = 5'b11011;
    exp5_q.push_back(3);
    step(1);
    chk("n5_nonowner_lock", owner5, 3);
    req5_  = '1;
    lock5_ = '1;
    step(1);

    // ---------------- hold limit ----------------
    req4_ = 4'b1110;
    exp4_q.push_back(0);
    step(1);
    chk("hold_setup", owner4, 0);
    req4_ = 4'b0110;
    step(3);
    chk("hold_pre", owner4, 0);
`ifdef BUS_ARB_RR_HOLD_LIMIT_EN
    exp4_q.push_back(3);
    step(1);
    chk("hold_rotate", owner4, 3);
    req4_ = 4'b1110;
    exp4_q.push_back(0);
    step(1);
    chk("hold_back0", owner4, 0);
`else
    step(1);
    chk("hold_none", owner4, 0);
`endif
    lock4_ = 4'b1110;
    req4_  = 4'b0110;
    step(6);
    chk("hold_locked", owner4, 0);
    req4_  = '1;
    lock4_ = '1;
    step(1);
    chk("hold_unlock_park", owner4, 0);

    // ---------------- async reset mid-ownership ----------------
    req4_ = 4'b0111;
    exp4_q.push_back(3);
    step(1);
    chk("pre_rst_owner", owner4, 3);
    req4_ = 4'b0110;
    step(2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grnt", grnt4_, 4'b1011);
    chk("async_rst_owner", owner4, 2);
    chk("async_rst_chg", chg4, 0);
    req4_ = '1;
    step(1);
    rst_n = 1'b1;
    req4_ = 4'b0011;
    step(3);
    chk("post_rst_hold", owner4, 2);
`ifdef BUS_ARB_RR_HOLD_LIMIT_EN
    exp4_q.push_back(3);
    step(1);
    chk("post_rst_rotate", owner4, 3);
`else
    step(1);
    chk("post_rst_keep", owner4, 2);
`endif
    req4_ = '1;
    step(2);

    chk("exp4_q_drained", exp4_q.size(), 0);
    chk("exp5_q_drained", exp5_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bus_arbiter_rr
`default_nettype wire
